multicycle_controller: RTL

Sequencing controller for the multi-cycle RV32I core. It replaces the single-cycle decoder with a state machine that shares one memory port between instruction fetch and load/store, and tolerates variable-latency memory through a req/ready handshake. An optional multi-cycle mul/div unit is also supported. It sits between the instruction register and the datapath, drives every datapath select and write strobe, and counts retired instructions.

---
 rtl/opcodes.sv | 40 ++++
 rtl/alu_decode.sv | 68 ++++++
 rtl/multicycle_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/opcodes.sv
// RV32I opcode map plus the select encodings shared by the multi-cycle controller
// and its ALU decoder.
package opcodes;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] RWSEL_ALU = 2'd0;
    localparam logic [1:0] RWSEL_MEM = 2'd1;
    localparam logic [1:0] RWSEL_PC4 = 2'd2;
    localparam logic [1:0] RWSEL_MD  = 2'd3;

    localparam logic [1:0] PCSEL_PC4  = 2'd0;
    localparam logic [1:0] PCSEL_JUMP = 2'd1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        MDWAIT = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } ctl_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: datapath selects and the legality flag.
// Selects depend only on the instruction register, so they hold steady from DECODE on.
module alu_decode
    import opcodes::*;
#(
    parameter bit MULDIV = 1'b0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluctl,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] rwsel,
    output logic [1:0] pcsel,
    output logic [1:0] memwidth,
    output logic       memsext,
    output logic       legal
);

    always_comb begin
        aluctl   = ALU_ADD;
        asel     = 1'b0;
        bsel     = 1'b1;
        rwsel    = RWSEL_ALU;
        pcsel    = PCSEL_PC4;
        memwidth = funct3[1:0];
        memsext  = ~funct3[2];
        legal    = 1'b1;
        case (opcode)
            OPC_OP: begin
                bsel   = 1'b0;
                aluctl = {funct7[5], funct3};
                if (funct7 == FUNCT7_MULDIV) begin
                    legal = MULDIV;
                    rwsel = MULDIV ? RWSEL_MD : RWSEL_ALU;
                end
            end
            // Only shifts read imm[10]; otherwise ADDI with a large immediate would become SUB.
            OPC_OPIMM: aluctl = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
            OPC_LOAD: begin
                rwsel = RWSEL_MEM;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: legal = ~funct3[2] && (funct3[1:0] != 2'b11);
            OPC_LUI:   ;
            OPC_AUIPC: asel = 1'b1;
            OPC_JAL: begin
                asel  = 1'b1;
                pcsel = PCSEL_JUMP;
                rwsel = RWSEL_PC4;
            end
            OPC_JALR: begin
                pcsel = PCSEL_JUMP;
                rwsel = RWSEL_PC4;
            end
            // pcsel[0]=1 takes the branch when the ALU result is non-zero.
            OPC_BRANCH: begin
                bsel   = 1'b0;
                pcsel  = {1'b1, funct3[0] ^ funct3[2]};
                aluctl = funct3[2] ? {3'b001, funct3[1]} : ALU_SUB;
                legal  = (funct3[2:1] != 2'b01);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV32I core: one shared memory port, req/ready
// handshake, optional mul/div handshake, and the retired-instruction counter.
module multicycle_controller
    import opcodes::*;
#(
    parameter bit MULDIV  = 1'b0,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               mem_ready,
    input  logic               md_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_ifetch,
    output logic [1:0]         memwidth,
    output logic               memsext,
    output logic [3:0]         aluctl,
    output logic               asel,
    output logic               bsel,
    output logic [1:0]         rwsel,
    output logic [1:0]         pcsel,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regw,
    output logic               md_start,
    output logic               trap,
    output logic [COUNT_W-1:0] instret,
    output ctl_state_t         state
);

    // Memory handshake: mem_req is held with stable mem_we/mem_ifetch until the
    // cycle mem_ready is seen; that cycle completes the access. mem_ready while
    // mem_req=0 has no effect.

    ctl_state_t state_q, state_d;
    logic       legal;
    logic       is_branch, is_load, is_store, is_md;
    logic       req_c, we_c, ifetch_c, irwrite_c, pcwrite_c, regw_c, mdstart_c;

    alu_decode #(.MULDIV(MULDIV)) u_alu_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .aluctl   (aluctl),
        .asel     (asel),
        .bsel     (bsel),
        .rwsel    (rwsel),
        .pcsel    (pcsel),
        .memwidth (memwidth),
        .memsext  (memsext),
        .legal    (legal)
    );

    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_md     = MULDIV && (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        ifetch_c  = 1'b0;
        irwrite_c = 1'b0;
        pcwrite_c = 1'b0;
        regw_c    = 1'b0;
        mdstart_c = 1'b0;
        case (state_q)
            FETCH: begin
                req_c    = 1'b1;
                ifetch_c = 1'b1;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: state_d = legal ? EXEC : TRAP;
            EXEC: begin
                if (is_branch) begin
                    pcwrite_c = 1'b1;
                    state_d   = FETCH;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else if (is_md) begin
                    mdstart_c = 1'b1;
                    state_d   = MDWAIT;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                req_c = 1'b1;
                we_c  = is_store;
                if (mem_ready) begin
                    pcwrite_c = is_store;
                    state_d   = is_store ? FETCH : WB;
                end
            end
            MDWAIT: if (md_done) state_d = WB;
            WB: begin
                regw_c    = 1'b1;
                pcwrite_c = 1'b1;
                state_d   = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Reset masks every strobe in the same cycle, abandoning any pending request.
    assign mem_req    = req_c & ~rst;
    assign mem_we     = we_c & ~rst;
    assign mem_ifetch = ifetch_c & ~rst;
    assign irwrite    = irwrite_c & ~rst;
    assign pcwrite    = pcwrite_c & ~rst;
    assign regw       = regw_c & ~rst;
    assign md_start   = mdstart_c & ~rst;
    assign trap       = (state_q == TRAP) & ~rst;
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (pcwrite) instret <= instret + COUNT_W'(1);
        end
    end

endmodule
